// File: rtl/lcd_read_ctrl.sv
// HD44780 read-cycle engine: runs RW=1 bus cycles and returns the BF/AC or data byte.
// Optional busy-flag polling is compiled in with `define LCD_BF_POLL_EN.
module lcd_read_ctrl #(
    parameter int unsigned T_SETUP  = 2,
    parameter int unsigned T_EHIGH  = 16,
    parameter int unsigned T_ELOW   = 16,
    parameter int unsigned POLL_MAX = 1000
) (
    input  logic       iCLK_50MHZ,
    input  logic       iRST,
    input  logic       iREQ,
    input  logic       iRS,
    output logic       oREADY,
    output logic [7:0] oDATA,
    output logic       oVALID,
    output logic       oTIMEOUT,
    output logic       oACTIVE,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E,
    inout  wire  [7:0] DATA_BUS
);

    if (T_SETUP < 1 || T_SETUP > 255 || T_EHIGH < 1 || T_EHIGH > 255 ||
        T_ELOW < 1 || T_ELOW > 255 || POLL_MAX < 1 || POLL_MAX > 65535) begin : g_bad_param
        $error("lcd_read_ctrl: timing or poll parameter out of range");
    end

    typedef enum logic [2:0] {StIdle, StSetup, StEhigh, StElow, StDone} state_e;

    // Counters hold "cycles remaining minus one" so the last cycle of a phase reads zero.
    localparam logic [7:0] SetupLoad = 8'(T_SETUP - 1);
    localparam logic [7:0] EhighLoad = 8'(T_EHIGH - 1);
    localparam logic [7:0] ElowLoad  = 8'(T_ELOW - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] cap_q, cap_d;
    logic [7:0] data_q, data_d;
    logic       rs_q, rs_d;

    // The block only ever listens on the shared bus.
    assign DATA_BUS = 8'hzz;

`ifdef LCD_BF_POLL_EN
    localparam logic [15:0] PollLast = 16'(POLL_MAX - 1);

    logic [15:0] poll_q, poll_d;
    logic        timeout_q, timeout_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        data_d  = data_q;
        rs_d    = rs_q;
`ifdef LCD_BF_POLL_EN
        poll_d    = poll_q;
        timeout_d = timeout_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (iREQ) begin
                    rs_d    = iRS;
                    cnt_d   = SetupLoad;
                    state_d = StSetup;
`ifdef LCD_BF_POLL_EN
                    poll_d    = '0;
                    timeout_d = 1'b0;
`endif
                end
            end
            StSetup: begin
                if (cnt_q == 8'd0) begin
                    cnt_d   = EhighLoad;
                    state_d = StEhigh;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StEhigh: begin
                if (cnt_q == 8'd0) begin
                    cap_d   = DATA_BUS;
                    cnt_d   = ElowLoad;
                    state_d = StElow;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StElow: begin
                if (cnt_q == 8'd0) begin
                    data_d  = cap_q;
                    state_d = StDone;
`ifdef LCD_BF_POLL_EN
                    // poll_q counts reads already retried; the current read is poll_q+1.
                    if (!rs_q && cap_q[7]) begin
                        if (poll_q < PollLast) begin
                            poll_d  = poll_q + 16'd1;
                            data_d  = data_q;
                            cnt_d   = SetupLoad;
                            state_d = StSetup;
                        end else begin
                            timeout_d = 1'b1;
                        end
                    end
`endif
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge iCLK_50MHZ) begin
        if (iRST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            cap_q   <= '0;
            data_q  <= '0;
            rs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
        end
    end

`ifdef LCD_BF_POLL_EN
    always_ff @(posedge iCLK_50MHZ) begin
        if (iRST) begin
            poll_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            poll_q    <= poll_d;
            timeout_q <= timeout_d;
        end
    end

    assign oTIMEOUT = timeout_q;
`else
    assign oTIMEOUT = 1'b0;
`endif

    always_comb begin
        oREADY  = (state_q == StIdle);
        oACTIVE = (state_q != StIdle);
        oVALID  = (state_q == StDone);
        LCD_E   = (state_q == StEhigh);
        LCD_RW  = oACTIVE;
        LCD_RS  = oACTIVE & rs_q;
        oDATA   = data_q;
    end

endmodule

// File: tb/tb_lcd_read_ctrl.sv
// Scoreboard bench for lcd_read_ctrl: driver queues expected reads, monitor checks each oVALID.
// Covers both builds; polling cases change expectations under LCD_BF_POLL_EN.
module tb_lcd_read_ctrl;

    localparam int unsigned TSetup  = 2;
    localparam int unsigned TEhigh  = 16;
    localparam int unsigned TElow   = 16;
    localparam int unsigned PollMax = 5;
    localparam int          IterCyc = TSetup + TEhigh + TElow;

    logic       clk = 1'b0;
    logic       irst = 1'b1;
    logic       ireq = 1'b0;
    logic       irs = 1'b0;
    logic       oready, ovalid, otimeout, oactive;
    logic [7:0] odata;
    logic       lcd_rs, lcd_rw, lcd_e;
    wire  [7:0] data_bus;

    lcd_read_ctrl #(
        .T_SETUP  (TSetup),
        .T_EHIGH  (TEhigh),
        .T_ELOW   (TElow),
        .POLL_MAX (PollMax)
    ) dut (
        .iCLK_50MHZ (clk),
        .iRST       (irst),
        .iREQ       (ireq),
        .iRS        (irs),
        .oREADY     (oready),
        .oDATA      (odata),
        .oVALID     (ovalid),
        .oTIMEOUT   (otimeout),
        .oACTIVE    (oactive),
        .LCD_RS     (lcd_rs),
        .LCD_RW     (lcd_rw),
        .LCD_E      (lcd_e),
        .DATA_BUS   (data_bus)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // LCD model: the n-th E pulse of the current table gets entry n (last entry repeats).
    logic [7:0] resp_tbl [4];
    int         resp_n = 1;
    int         e_base = 0;
    int         e_count = 0;
    int         idx;
    logic [7:0] bus_drv;

    always @(posedge lcd_e) e_count <= e_count + 1;

    always_comb begin
        idx = e_count - e_base - 1;
        if (idx < 0) idx = 0;
        if (idx >= resp_n) idx = resp_n - 1;
        bus_drv = resp_tbl[idx];
    end

    assign data_bus = lcd_e ? bus_drv : 8'hzz;

    typedef struct {
        logic [7:0] data;
        logic       to;
        logic       rs;
        int         pulses;
    } exp_t;

    exp_t sb_q[$];

    int         idle_req_cnt = 0;
    logic [7:0] idle_exp_data = 8'h00;

    // ---------------- monitor / checker ----------------
    int   n_tests = 0;
    int   n_fail = 0;
    int   idle_done_cnt = 0;
    logic act_prev = 1'b0;
    logic e_prev = 1'b0;
    logic t_rs = 1'b0;
    logic rs_bad = 1'b0;
    int   acc_cyc = 0;
    int   pulses = 0;
    int   first_rise = 0;
    int   ehw = 0;
    int   wmin = 0;
    int   wmax = 0;
    int   wd = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (idle_req_cnt != idle_done_cnt) begin
            chk("idle_lcd_e", int'(lcd_e), 0);
            chk("idle_lcd_rw", int'(lcd_rw), 0);
            chk("idle_lcd_rs", int'(lcd_rs), 0);
            chk("idle_oready", int'(oready), 1);
            chk("idle_oactive", int'(oactive), 0);
            chk("idle_ovalid", int'(ovalid), 0);
            chk("idle_otimeout", int'(otimeout), 0);
            chk("idle_odata", int'(odata), int'(idle_exp_data));
            idle_done_cnt++;
        end

        if (oactive && !act_prev) begin
            acc_cyc    = cyc - 1;
            pulses     = 0;
            first_rise = 0;
            wmin       = 1000;
            wmax       = 0;
            rs_bad     = 1'b0;
            t_rs       = (sb_q.size() > 0) ? sb_q[0].rs : 1'b0;
        end
        if (oactive && (lcd_rw !== 1'b1 || lcd_rs !== t_rs)) rs_bad = 1'b1;
        if (lcd_e && !e_prev) begin
            pulses++;
            if (pulses == 1) first_rise = cyc - acc_cyc;
            ehw = 0;
        end
        if (lcd_e) ehw++;
        if (!lcd_e && e_prev) begin
            if (ehw < wmin) wmin = ehw;
            if (ehw > wmax) wmax = ehw;
        end

        if (ovalid) begin
            wd = 0;
            if (sb_q.size() == 0) begin
                chk("unexpected_ovalid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("rd_data", int'(odata), int'(e.data));
                chk("rd_timeout", int'(otimeout), int'(e.to));
                chk("rd_pulses", pulses, e.pulses);
                chk("rd_latency", cyc - acc_cyc, IterCyc * e.pulses + 1);
                chk("rd_first_e_rise", first_rise, int'(TSetup) + 1);
                chk("rd_e_width_min", wmin, int'(TEhigh));
                chk("rd_e_width_max", wmax, int'(TEhigh));
                chk("rd_rs_rw_stable", int'(rs_bad), 0);
            end
        end else if (sb_q.size() > 0) begin
            wd++;
            if (wd > 600) begin
                chk("ovalid_timeout", 0, 1);
                void'(sb_q.pop_front());
                wd = 0;
            end
        end

        act_prev = oactive;
        e_prev   = lcd_e;
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load_resp(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input int n);
        resp_tbl[0] = b0;
        resp_tbl[1] = b1;
        resp_tbl[2] = b2;
        resp_tbl[3] = b3;
        resp_n      = n;
        e_base      = e_count;
    endtask

    task automatic do_req(input logic rs, input logic [7:0] data, input logic to,
                          input int npulse, input bit push, input int hold);
        exp_t e;
        int   n;
        e.data   = data;
        e.to     = to;
        e.rs     = rs;
        e.pulses = npulse;
        if (push) sb_q.push_back(e);
        ireq = 1'b1;
        irs  = rs;
        n    = 0;
        while (!oready && n < 300) begin
            step();
            n++;
        end
        step();
        for (int i = 0; i < hold; i++) begin
            irs = ~irs;
            step();
        end
        ireq = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() > 0 && n < 1000) begin
            step();
            n++;
        end
        step();
    endtask

    task automatic idle_check(input logic [7:0] d);
        idle_exp_data = d;
        idle_req_cnt++;
        step();
    endtask

    initial begin
        load_resp(8'h00, 8'h00, 8'h00, 8'h00, 1);
        repeat (3) step();
        irst = 1'b0;
        idle_check(8'h00);

        // Data register read
        load_resp(8'h41, 8'h41, 8'h41, 8'h41, 1);
        do_req(1'b1, 8'h41, 1'b0, 1, 1'b1, 0);
        drain();
        idle_check(8'h41);

        // Busy flag set: single read, or polled to exhaustion
        load_resp(8'h85, 8'h85, 8'h85, 8'h85, 1);
`ifdef LCD_BF_POLL_EN
        do_req(1'b0, 8'h85, 1'b1, PollMax, 1'b1, 0);
`else
        do_req(1'b0, 8'h85, 1'b0, 1, 1'b1, 0);
`endif
        drain();

        // Busy flag clear
        load_resp(8'h3C, 8'h3C, 8'h3C, 8'h3C, 1);
        do_req(1'b0, 8'h3C, 1'b0, 1, 1'b1, 0);
        drain();

        // Busy for three reads, then free
        load_resp(8'h8A, 8'h8A, 8'h8A, 8'h0A, 4);
`ifdef LCD_BF_POLL_EN
        do_req(1'b0, 8'h0A, 1'b0, 4, 1'b1, 0);
`else
        do_req(1'b0, 8'h8A, 1'b0, 1, 1'b1, 0);
`endif
        drain();

        // Reset in the middle of the E pulse: no result, outputs back to reset values
        load_resp(8'h99, 8'h99, 8'h99, 8'h99, 1);
        do_req(1'b1, 8'h00, 1'b0, 1, 1'b0, 0);
        for (int i = 0; i < 200 && !lcd_e; i++) step();
        repeat (4) step();
        irst = 1'b1;
        step();
        irst = 1'b0;
        idle_req_cnt++;
        idle_exp_data = 8'h00;
        repeat (40) step();

        // Normal read after the aborted one
        load_resp(8'hC3, 8'hC3, 8'hC3, 8'hC3, 1);
        do_req(1'b1, 8'hC3, 1'b0, 1, 1'b1, 0);
        drain();

        // iREQ held with iRS toggling while busy: latched RS kept, no extra read
        load_resp(8'h5A, 8'h5A, 8'h5A, 8'h5A, 1);
        do_req(1'b1, 8'h5A, 1'b0, 1, 1'b1, 20);
        drain();
        repeat (5) step();

        // Back-to-back requests
        load_resp(8'h27, 8'h27, 8'h27, 8'h27, 1);
        do_req(1'b1, 8'h27, 1'b0, 1, 1'b1, 0);
        do_req(1'b1, 8'h27, 1'b0, 1, 1'b1, 0);
        drain();
        idle_check(8'h27);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
